serial_word_assembler: RTL and testbench

- Upstream stage of the team's enabled parallel register.
- Collects a serial bit stream, qualified by a per-bit strobe, into WIDTH-bit words.
- Presents each completed word on `word` with a one-cycle `word_valid` pulse. `word_valid` connects directly to the downstream register's enable and `word` to its data input.
- Supports MSB-first or LSB-first ordering, a synchronous frame-resync input, and an overrun flag for strobes that arrive while the host has not consumed the previous word.

---
 rtl/serial_word_assembler_if.sv | 27 ++
 rtl/serial_word_assembler.sv | 84 ++++++++
 tb/tb_serial_word_assembler.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/serial_word_assembler_if.sv
// Handshake bundle between the serial word assembler and its host.
// The master side drives serial bits and acknowledges; the slave side (the assembler) reports words.
interface serial_word_assembler_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);
  logic             bit_valid;
  logic             bit_in;
  logic             frame_start;
  logic             word_ack;
  logic [WIDTH-1:0] word;
  logic             word_valid;
  logic             word_pending;
  logic             overrun;
  logic             busy;
  logic [CNT_W-1:0] bit_count;

  modport master (
    output bit_valid, bit_in, frame_start, word_ack,
    input  word, word_valid, word_pending, overrun, busy, bit_count
  );

  modport slave (
    input  bit_valid, bit_in, frame_start, word_ack,
    output word, word_valid, word_pending, overrun, busy, bit_count
  );
endinterface

// File: rtl/serial_word_assembler.sv
// Assembles a strobed serial bit stream into WIDTH-bit words, MSB- or LSB-first,
// with frame resync, a pending/ack handshake and a sticky overrun flag.
module serial_word_assembler #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(WIDTH + 1)
) (
  input logic                    clk,
  input logic                    reset,
  serial_word_assembler_if.slave bus
);

  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word_r;
  logic             word_valid_r;
  logic             word_pending_r;
  logic             overrun_r;
  logic             busy_r;

  logic [WIDTH-1:0] base_sr;
  logic [CNT_W-1:0] base_cnt;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic [WIDTH-1:0] nxt_sr;
  logic [CNT_W-1:0] nxt_cnt;

  // frame_start clears the partial word first, so an accompanying strobe becomes bit 0.
  // Shifts are written without part-selects so WIDTH=1 stays legal.
  always_comb begin
    base_sr  = bus.frame_start ? '0 : sr;
    base_cnt = bus.frame_start ? '0 : cnt;
    if (MSB_FIRST != 0)
      shifted = (base_sr << 1) | WIDTH'(bus.bit_in);
    else
      shifted = (base_sr >> 1) | (WIDTH'(bus.bit_in) << (WIDTH - 1));
    complete = bus.bit_valid && (base_cnt == CNT_W'(WIDTH - 1));
    nxt_sr   = base_sr;
    nxt_cnt  = base_cnt;
    if (bus.bit_valid) begin
      if (complete) begin
        nxt_sr  = '0;
        nxt_cnt = '0;
      end else begin
        nxt_sr  = shifted;
        nxt_cnt = base_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr             <= '0;
      cnt            <= '0;
      word_r         <= '0;
      word_valid_r   <= 1'b0;
      word_pending_r <= 1'b0;
      overrun_r      <= 1'b0;
      busy_r         <= 1'b0;
    end else begin
      sr           <= nxt_sr;
      cnt          <= nxt_cnt;
      busy_r       <= (nxt_cnt != '0);
      word_valid_r <= complete;
      if (complete) begin
        word_r         <= shifted;
        word_pending_r <= 1'b1;
        // An ack on the completion edge consumes the old word, so no overrun.
        if (word_pending_r && !bus.word_ack)
          overrun_r <= 1'b1;
      end else if (bus.word_ack) begin
        word_pending_r <= 1'b0;
      end
    end
  end

  assign bus.word         = word_r;
  assign bus.word_valid   = word_valid_r;
  assign bus.word_pending = word_pending_r;
  assign bus.overrun      = overrun_r;
  assign bus.busy         = busy_r;
  assign bus.bit_count    = cnt;

endmodule

// File: tb/tb_serial_word_assembler.sv
// Bench for serial_word_assembler: MSB-first, LSB-first (WIDTH=8) and WIDTH=1 instances
// share one stimulus stream and are checked every cycle against a bit-list model.
module tb_serial_word_assembler;

  logic clk;
  logic reset;

  serial_word_assembler_if #(.WIDTH(8)) if_m ();
  serial_word_assembler_if #(.WIDTH(8)) if_l ();
  serial_word_assembler_if #(.WIDTH(1)) if_1 ();

  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(1)) dut_m (.clk(clk), .reset(reset), .bus(if_m));
  serial_word_assembler #(.WIDTH(8), .MSB_FIRST(0)) dut_l (.clk(clk), .reset(reset), .bus(if_l));
  serial_word_assembler #(.WIDTH(1), .MSB_FIRST(1)) dut_1 (.clk(clk), .reset(reset), .bus(if_1));

  assign if_l.bit_valid   = if_m.bit_valid;
  assign if_l.bit_in      = if_m.bit_in;
  assign if_l.frame_start = if_m.frame_start;
  assign if_l.word_ack    = if_m.word_ack;
  assign if_1.bit_valid   = if_m.bit_valid;
  assign if_1.bit_in      = if_m.bit_in;
  assign if_1.frame_start = if_m.frame_start;
  assign if_1.word_ack    = if_m.word_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a list of accepted bits; the word is built by positional arithmetic on completion.
  int         nbits = 0;
  bit         coll[8];
  logic [7:0] exp_wm = '0, exp_wl = '0;
  bit         exp_v = 0, exp_p = 0, exp_o = 0;
  bit         exp_w1 = 0, exp_v1 = 0, exp_p1 = 0, exp_o1 = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      nbits = 0; exp_wm = '0; exp_wl = '0; exp_v = 0; exp_p = 0; exp_o = 0;
      exp_w1 = 0; exp_v1 = 0; exp_p1 = 0; exp_o1 = 0;
    end else begin
      exp_v  = 0;
      exp_v1 = if_m.bit_valid;
      if (if_m.frame_start) nbits = 0;
      if (if_m.bit_valid) begin
        coll[nbits] = if_m.bit_in;
        nbits++;
        if (nbits == 8) begin
          exp_wm = 0; exp_wl = 0;
          for (int i = 0; i < 8; i++) begin
            exp_wm = exp_wm + (8'(coll[i]) << (7 - i));
            exp_wl = exp_wl + (8'(coll[i]) << i);
          end
          exp_v = 1;
          nbits = 0;
        end
      end
      if (exp_v) begin
        if (exp_p && !if_m.word_ack) exp_o = 1;
        exp_p = 1;
      end else if (if_m.word_ack) exp_p = 0;
      if (exp_v1) begin
        exp_w1 = if_m.bit_in;
        if (exp_p1 && !if_m.word_ack) exp_o1 = 1;
        exp_p1 = 1;
      end else if (if_m.word_ack) exp_p1 = 0;
    end
  end

  always @(negedge clk) begin
    chk("m.word", 32'(if_m.word), 32'(exp_wm));
    chk("l.word", 32'(if_l.word), 32'(exp_wl));
    chk("m.word_valid", 32'(if_m.word_valid), 32'(exp_v));
    chk("l.word_valid", 32'(if_l.word_valid), 32'(exp_v));
    chk("m.word_pending", 32'(if_m.word_pending), 32'(exp_p));
    chk("m.overrun", 32'(if_m.overrun), 32'(exp_o));
    chk("l.overrun", 32'(if_l.overrun), 32'(exp_o));
    chk("m.busy", 32'(if_m.busy), 32'(nbits != 0));
    chk("m.bit_count", 32'(if_m.bit_count), 32'(nbits));
    chk("l.bit_count", 32'(if_l.bit_count), 32'(nbits));
    chk("w1.word", 32'(if_1.word), 32'(exp_w1));
    chk("w1.word_valid", 32'(if_1.word_valid), 32'(exp_v1));
    chk("w1.word_pending", 32'(if_1.word_pending), 32'(exp_p1));
    chk("w1.overrun", 32'(if_1.overrun), 32'(exp_o1));
    chk("w1.bit_count", 32'(if_1.bit_count), 32'(0));
    chk("w1.busy", 32'(if_1.busy), 32'(0));
  end

  task automatic step(input bit bv, input bit bi, input bit fs, input bit ack);
    if_m.bit_valid = bv; if_m.bit_in = bi; if_m.frame_start = fs; if_m.word_ack = ack;
    @(negedge clk);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Sends v MSB-first in time; optional idle gaps and an ack on the final bit.
  task automatic send_word(input logic [7:0] v, input bit gaps, input bit ack_last);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, v[i], 1'b0, (i == 0) ? ack_last : 1'b0);
      if (gaps && i != 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    if_m.bit_valid = 0; if_m.bit_in = 0; if_m.frame_start = 0; if_m.word_ack = 0;
    #2 reset = 1'b1;
    #1;
    chk("reset.word", 32'(if_m.word), 32'h0);
    chk("reset.word_valid", 32'(if_m.word_valid), 32'h0);
    chk("reset.pending", 32'(if_m.word_pending), 32'h0);
    chk("reset.overrun", 32'(if_m.overrun), 32'h0);
    chk("reset.busy", 32'(if_m.busy), 32'h0);
    chk("reset.bit_count", 32'(if_m.bit_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1,1,0,1,0,0,0,0 back to back: 0xD0 MSB-first, 0x0B LSB-first.
    send_word(8'hD0, 1'b0, 1'b0);
    chk("lit.msb_word", 32'(if_m.word), 32'hD0);
    chk("lit.lsb_word", 32'(if_l.word), 32'h0B);
    chk("lit.valid", 32'(if_m.word_valid), 32'h1);
    chk("lit.pending", 32'(if_m.word_pending), 32'h1);
    step(0, 0, 0, 1);
    chk("lit.valid_one_cycle", 32'(if_m.word_valid), 32'h0);
    chk("lit.ack_clears", 32'(if_m.word_pending), 32'h0);

    // 0xA5 with gaps; busy must span the idle cycles.
    send_word(8'hA5, 1'b1, 1'b0);
    chk("lit.gap_word", 32'(if_m.word), 32'hA5);
    chk("lit.gap_lsb_word", 32'(if_l.word), 32'hA5);
    step(0, 0, 0, 1);

    // Resync after 3 bits: new word is 1 followed by 0000001.
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("lit.resync_count", 32'(if_m.bit_count), 32'h1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    chk("lit.resync_word", 32'(if_m.word), 32'h81);
    chk("lit.resync_lsb_word", 32'(if_l.word), 32'h81);

    // Overrun: two words without ack.
    do_reset();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b0);
    chk("lit.overrun_set", 32'(if_m.overrun), 32'h1);
    chk("lit.overrun_word", 32'(if_m.word), 32'h5A);
    // Ack on the second completion edge prevents overrun.
    do_reset();
    send_word(8'h3C, 1'b0, 1'b0);
    send_word(8'h5A, 1'b0, 1'b1);
    chk("lit.ack_race_overrun", 32'(if_m.overrun), 32'h0);
    chk("lit.ack_race_pending", 32'(if_m.word_pending), 32'h1);

    // Asynchronous reset between edges after 5 bits.
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("lit.async_count", 32'(if_m.bit_count), 32'h0);
    chk("lit.async_busy", 32'(if_m.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    send_word(8'hC3, 1'b0, 1'b0);
    chk("lit.after_reset_word", 32'(if_m.word), 32'hC3);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++)
      step(($urandom % 10) < 6, 1'($urandom), ($urandom % 16) == 0, ($urandom % 6) == 0);
    step(0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
